ps2_host_tx: RTL

PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset), over the same two-wire bus the PS2 receiver listens on. It drives both lines open-drain through active-high pull-low enables, clocks bits out on device-generated falling edges, and checks the device acknowledge. It sits beside PS2 in snake_top; tx_busy gates the receiver while a transmission is in progress.

---
 rtl/ps2_host_tx.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_host_tx : sends one command byte to a PS/2 device, checks its ACK     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 10000,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int FILT        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_req,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int FW = $clog2(FILT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_SEND      = 3'd2,
    S_ACK       = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          clk_flt_q, clk_flt_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          fe;

  state_t        state_q, state_d;
  logic [9:0]    frame_q, frame_d;
  logic [3:0]    idx_q, idx_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [TW-1:0] to_q, to_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          timeout;

  // A new clock level is accepted only after FILT consecutive differing samples.
  always_comb begin
    clk_flt_d = clk_flt_q;
    flt_cnt_d = '0;
    if (clk_s2_q != clk_flt_q) begin
      if (flt_cnt_q == FW'(FILT - 1)) clk_flt_d = clk_s2_q;
      else                            flt_cnt_d = flt_cnt_q + 1'b1;
    end
  end

  assign fe      = clk_flt_q & ~clk_s2_q & (flt_cnt_q == FW'(FILT - 1));
  assign timeout = (to_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    idx_d     = idx_q;
    inh_d     = inh_q;
    to_d      = '0;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_req) begin
          frame_d  = {1'b1, ~^tx_data, tx_data};
          busy_d   = 1'b1;
          clk_oe_d = 1'b1;
          inh_d    = '0;
          state_d  = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        inh_d = inh_q + 1'b1;
        if (inh_q == IW'(INHIBIT_CYC - 1)) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          idx_d     = '0;
          state_d   = S_SEND;
        end
      end

      S_SEND: begin
        to_d = to_q + 1'b1;
        if (fe) begin
          to_d      = '0;
          data_oe_d = ~frame_q[idx_q];
          idx_d     = idx_q + 4'd1;
          if (idx_q == 4'd9) state_d = S_ACK;
        end else if (timeout) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          busy_d    = 1'b0;
          err_d     = 1'b1;
          state_d   = S_IDLE;
        end
      end

      S_ACK: begin
        to_d = to_q + 1'b1;
        if (fe) begin
          to_d = '0;
          if (!dat_s2_q) begin
            state_d = S_WAIT_IDLE;
          end else begin
            busy_d  = 1'b0;
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (timeout) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          busy_d    = 1'b0;
          err_d     = 1'b1;
          state_d   = S_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        to_d = to_q + 1'b1;
        if (clk_flt_q && dat_s2_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (timeout) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          busy_d    = 1'b0;
          err_d     = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // Synchronizers reset to the idle (released, high) bus level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      clk_flt_q <= 1'b1;
      flt_cnt_q <= '0;
      state_q   <= S_IDLE;
      frame_q   <= '0;
      idx_q     <= '0;
      inh_q     <= '0;
      to_q      <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      clk_s1_q  <= ps2_clk_i;
      clk_s2_q  <= clk_s1_q;
      dat_s1_q  <= ps2_data_i;
      dat_s2_q  <= dat_s1_q;
      clk_flt_q <= clk_flt_d;
      flt_cnt_q <= flt_cnt_d;
      state_q   <= state_d;
      frame_q   <= frame_d;
      idx_q     <= idx_d;
      inh_q     <= inh_d;
      to_q      <= to_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;

endmodule
`default_nettype wire
